// File: rtl/axi_apb_arbiter.sv
// axi_apb_arbiter: round-robin sharing of one downstream APB slave between two APB requesters,
// with registered outputs and an optional ACCESS-phase timeout.
module axi_apb_arbiter #(
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [1:0]                      S_PSEL,
    input  logic [1:0]                      S_PENABLE,
    input  logic [2*AXI_ADDR_WIDTH-1:0]     S_PADDR,
    input  logic [1:0]                      S_PWRITE,
    input  logic [2*AXI_DATA_WIDTH-1:0]     S_PWDATA,
    input  logic [2*AXI_DATA_WIDTH/8-1:0]   S_PSTRB,
    input  logic [5:0]                      S_PPROT,
    output logic [1:0]                      S_PREADY,
    output logic [AXI_DATA_WIDTH-1:0]       S_PRDATA,
    output logic                            S_PSLVERR,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [AXI_ADDR_WIDTH-1:0]       PADDR,
    output logic [AXI_DATA_WIDTH-1:0]       PWDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]     PSTRB,
    output logic [2:0]                      PPROT,
    input  logic                            PREADY,
    input  logic [AXI_DATA_WIDTH-1:0]       PRDATA,
    input  logic                            PSLVERR,
    output logic                            GRANT
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    r_state, w_nxt;
    logic          r_grant, w_win, w_tmo;
    logic [CW-1:0] r_cnt, w_cnt_inc;
    logic          r_psel, r_penable, r_pwrite, r_sslverr;
    logic [AW-1:0] r_paddr, w_paddr;
    logic [DW-1:0] r_pwdata, r_srdata, w_pwdata;
    logic [SW-1:0] r_pstrb, w_pstrb;
    logic [2:0]    r_pprot, w_pprot;
    logic [1:0]    r_sready;
    logic          w_pwrite;
    logic          w_unused;

    // A requester counts as pending on PSEL alone, so the enable phase carries no information here
    assign w_unused = ^S_PENABLE;

    // Round-robin: on contention the requester that did not own the last transfer wins
    assign w_win    = (S_PSEL == 2'b11) ? ~r_grant : S_PSEL[1];
    assign w_paddr  = w_win ? S_PADDR[2*AW-1:AW]   : S_PADDR[AW-1:0];
    assign w_pwdata = w_win ? S_PWDATA[2*DW-1:DW]  : S_PWDATA[DW-1:0];
    assign w_pstrb  = w_win ? S_PSTRB[2*SW-1:SW]   : S_PSTRB[SW-1:0];
    assign w_pprot  = w_win ? S_PPROT[5:3]         : S_PPROT[2:0];
    assign w_pwrite = w_win ? S_PWRITE[1]          : S_PWRITE[0];

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == TO);

    assign w_nxt = (r_state == IDLE)   ? (|S_PSEL ? SETUP : IDLE) :
                   (r_state == SETUP)  ? ACCESS :
                   (r_state == ACCESS) ? ((PREADY || w_tmo) ? DONE : ACCESS) : IDLE;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state   <= IDLE;
            r_grant   <= 1'b1;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
            r_sready  <= '0;
            r_srdata  <= '0;
            r_sslverr <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_psel    <= (w_nxt == SETUP) || (w_nxt == ACCESS);
            r_penable <= w_nxt == ACCESS;
            r_sready  <= (w_nxt == DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
            if (r_state == IDLE && |S_PSEL) begin
                r_grant  <= w_win;
                r_paddr  <= w_paddr;
                r_pwdata <= w_pwdata;
                r_pstrb  <= w_pstrb;
                r_pprot  <= w_pprot;
                r_pwrite <= w_pwrite;
            end
            if (r_state == SETUP)
                r_cnt <= '0;
            else if (r_state == ACCESS && !PREADY)
                r_cnt <= w_cnt_inc;
            // A real PREADY takes precedence over a timeout landing on the same edge
            if (r_state == ACCESS && w_nxt == DONE) begin
                r_srdata  <= (PREADY && !r_pwrite) ? PRDATA : '0;
                r_sslverr <= PREADY ? PSLVERR : 1'b1;
            end
        end
    end

    assign S_PREADY  = r_sready;
    assign S_PRDATA  = r_srdata;
    assign S_PSLVERR = r_sslverr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;
    assign GRANT     = r_grant;
endmodule

// File: tb/tb_axi_apb_arbiter.sv
// tb_axi_apb_arbiter: two APB requester drivers and a slave model feed the arbiter;
// expected completions are queued by the stimulus and checked by a separate monitor.
module tb_axi_apb_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      S_PSEL = '0, S_PENABLE = '0, S_PWRITE = '0;
    logic [2*AW-1:0] S_PADDR = '0;
    logic [2*DW-1:0] S_PWDATA = '0;
    logic [2*SW-1:0] S_PSTRB = '0;
    logic [5:0]      S_PPROT = '0;
    logic [1:0]      S_PREADY;
    logic [DW-1:0]   S_PRDATA;
    logic            S_PSLVERR;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [SW-1:0]   PSTRB;
    logic [2:0]      PPROT;
    logic            PREADY = 1'b0;
    logic [DW-1:0]   PRDATA = '0;
    logic            PSLVERR = 1'b0;
    logic            GRANT;

    axi_apb_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
        .S_PWDATA(S_PWDATA), .S_PSTRB(S_PSTRB), .S_PPROT(S_PPROT),
        .S_PREADY(S_PREADY), .S_PRDATA(S_PRDATA), .S_PSLVERR(S_PSLVERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .GRANT(GRANT)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic          abort;
    } req_t;

    typedef struct {
        logic [1:0]    sready;
        logic          grant;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic [AW-1:0] paddr;
        logic          pwrite;
        logic [DW-1:0] pwdata;
        logic [SW-1:0] pstrb;
        logic [2:0]    pprot;
        int            acc;
    } exp_t;

    req_t rq0[$], rq1[$];
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    logic [1:0] busy = '0, rdy_seen = '0, abort_q = '0;
    int ws = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic slv_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [2:0] p, input logic ab);
        req_t r;
        r.addr = a; r.write = w; r.wdata = d; r.strb = s; r.prot = p; r.abort = ab;
        if (i == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic exp_push(input logic [1:0] sr, input logic g, input logic [DW-1:0] rd, input logic er,
                            input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] p, input int acc);
        exp_t e;
        e.sready = sr; e.grant = g; e.rdata = rd; e.slverr = er; e.paddr = a;
        e.pwrite = w; e.pwdata = d; e.pstrb = s; e.pprot = p; e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || busy != 2'b00 || rq0.size() != 0 || rq1.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        if (n >= max) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d completions still outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Slave model: ws wait states, and deliberately noisy PREADY/PRDATA/PSLVERR outside ACCESS
    initial begin : slave
        int sacc;
        sacc = 0;
        forever begin
            @(negedge clk);
            if (PSEL && PENABLE) begin
                PREADY  = (sacc == ws);
                PRDATA  = PWRITE ? 32'hBAD0BAD0 : slv_rdata;
                PSLVERR = PREADY ? slv_err : 1'b1;
                sacc++;
            end else begin
                sacc    = 0;
                PREADY  = 1'b1;
                PRDATA  = 32'hBAD0BAD0;
                PSLVERR = 1'b1;
            end
        end
    end

    // Requester drivers: standard APB setup/enable, PSEL kept high across back-to-back transfers
    initial begin : drv
        req_t r;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) begin
                    if (abort_q[i]) begin
                        S_PSEL[i] = 1'b0; busy[i] = 1'b0; abort_q[i] = 1'b0;
                    end else if (!S_PENABLE[i]) begin
                        S_PENABLE[i] = 1'b1;
                    end else if (rdy_seen[i]) begin
                        S_PSEL[i] = 1'b0; S_PENABLE[i] = 1'b0; busy[i] = 1'b0;
                    end
                end
                if (!busy[i] && ((i == 0) ? rq0.size() : rq1.size()) != 0) begin
                    if (i == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                    S_PADDR[i*AW +: AW]  = r.addr;
                    S_PWDATA[i*DW +: DW] = r.wdata;
                    S_PSTRB[i*SW +: SW]  = r.strb;
                    S_PPROT[i*3 +: 3]    = r.prot;
                    S_PWRITE[i]          = r.write;
                    S_PSEL[i]            = 1'b1;
                    S_PENABLE[i]         = 1'b0;
                    busy[i]              = 1'b1;
                    abort_q[i]           = r.abort;
                end
            end
        end
    end

    initial begin : mon
        int acc;
        exp_t e;
        logic [AW-1:0] m_paddr;
        logic [DW-1:0] m_pwdata;
        logic [SW-1:0] m_pstrb;
        logic [2:0] m_pprot;
        logic m_pwrite;
        acc = 0;
        m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0; m_pwrite = 1'b0;
        forever begin
            @(negedge clk);
            rdy_seen = S_PREADY;
            if (rst) begin
                acc = 0;
            end else begin
                if (PSEL && PENABLE) begin
                    acc++;
                    m_paddr = PADDR; m_pwdata = PWDATA; m_pstrb = PSTRB; m_pprot = PPROT; m_pwrite = PWRITE;
                end
                if (S_PREADY != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_s_pready", 64'(S_PREADY), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("s_pready",  64'(S_PREADY),  64'(e.sready));
                        chk("grant",     64'(GRANT),     64'(e.grant));
                        chk("s_prdata",  64'(S_PRDATA),  64'(e.rdata));
                        chk("s_pslverr", 64'(S_PSLVERR), 64'(e.slverr));
                        chk("paddr",     64'(m_paddr),   64'(e.paddr));
                        chk("pwrite",    64'(m_pwrite),  64'(e.pwrite));
                        chk("pwdata",    64'(m_pwdata),  64'(e.pwdata));
                        chk("pstrb",     64'(m_pstrb),   64'(e.pstrb));
                        chk("pprot",     64'(m_pprot),   64'(e.pprot));
                        chk("access_cycles", 64'(acc),   64'(e.acc));
                        chk("psel_in_done",  64'({PSEL, PENABLE}), 64'd0);
                    end
                    acc = 0;
                end
            end
        end
    end

    initial begin : stim
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",     64'(GRANT),     64'd1);
        chk("rst_s_pready",  64'(S_PREADY),  64'd0);
        chk("rst_psel",      64'(PSEL),      64'd0);
        chk("rst_penable",   64'(PENABLE),   64'd0);
        chk("rst_s_prdata",  64'(S_PRDATA),  64'd0);
        chk("rst_s_pslverr", 64'(S_PSLVERR), 64'd0);
        chk("rst_paddr",     64'(PADDR),     64'd0);
        chk("rst_pwdata",    64'(PWDATA),    64'd0);
        @(negedge clk) rst = 1'b0;
        // single zero-wait write from requester 0
        ws = 0; slv_err = 1'b0;
        add(0, 4'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0);
        exp_push(2'b01, 1'b0, 32'h0, 1'b0, 4'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 1);
        drain(100);
        // read from requester 1 with 3 wait states
        ws = 3; slv_rdata = 32'h12345678;
        add(1, 4'h2, 1'b0, 32'h0, 4'h0, 3'd5, 1'b0);
        exp_push(2'b10, 1'b1, 32'h12345678, 1'b0, 4'h2, 1'b0, 32'h0, 4'h0, 3'd5, 4);
        drain(100);
        // continuous contention alternates 0,1,0,1
        ws = 0;
        add(0, 4'h8, 1'b1, 32'h11111111, 4'h3, 3'd1, 1'b0);
        add(0, 4'h9, 1'b1, 32'h33333333, 4'hC, 3'd2, 1'b0);
        add(1, 4'hC, 1'b1, 32'h22222222, 4'hF, 3'd6, 1'b0);
        add(1, 4'hD, 1'b1, 32'h44444444, 4'h1, 3'd7, 1'b0);
        exp_push(2'b01, 1'b0, 32'h0, 1'b0, 4'h8, 1'b1, 32'h11111111, 4'h3, 3'd1, 1);
        exp_push(2'b10, 1'b1, 32'h0, 1'b0, 4'hC, 1'b1, 32'h22222222, 4'hF, 3'd6, 1);
        exp_push(2'b01, 1'b0, 32'h0, 1'b0, 4'h9, 1'b1, 32'h33333333, 4'hC, 3'd2, 1);
        exp_push(2'b10, 1'b1, 32'h0, 1'b0, 4'hD, 1'b1, 32'h44444444, 4'h1, 3'd7, 1);
        drain(200);
        // slave never ready: timeout after 16 ACCESS cycles
        ws = 255; slv_rdata = 32'h0F0F0F0F;
        add(0, 4'h6, 1'b0, 32'h0, 4'h0, 3'd3, 1'b0);
        exp_push(2'b01, 1'b0, 32'h0, 1'b1, 4'h6, 1'b0, 32'h0, 4'h0, 3'd3, 16);
        drain(100);
        // slave error on requester 1
        ws = 1; slv_err = 1'b1; slv_rdata = 32'hCAFEF00D;
        add(1, 4'hA, 1'b0, 32'h0, 4'h0, 3'd2, 1'b0);
        exp_push(2'b10, 1'b1, 32'hCAFEF00D, 1'b1, 4'hA, 1'b0, 32'h0, 4'h0, 3'd2, 2);
        drain(100);
        // requester drops PSEL mid-transfer: downstream transfer still completes
        ws = 0; slv_err = 1'b0; slv_rdata = 32'h55AA55AA;
        add(0, 4'h3, 1'b0, 32'h0, 4'h0, 3'd4, 1'b1);
        exp_push(2'b01, 1'b0, 32'h55AA55AA, 1'b0, 4'h3, 1'b0, 32'h0, 4'h0, 3'd4, 1);
        drain(100);
        // asynchronous reset in the middle of ACCESS
        ws = 255;
        add(1, 4'h7, 1'b1, 32'h77777777, 4'hF, 3'd0, 1'b0);
        n = 0;
        while (!(PSEL && PENABLE) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL access_wait: ACCESS not reached within 50 cycles, required it");
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_psel",     64'(PSEL),     64'd0);
        chk("arst_penable",  64'(PENABLE),  64'd0);
        chk("arst_s_pready", 64'(S_PREADY), 64'd0);
        chk("arst_grant",    64'(GRANT),    64'd1);
        chk("arst_s_prdata", 64'(S_PRDATA), 64'd0);
        busy = '0; abort_q = '0; S_PSEL = '0; S_PENABLE = '0;
        rq0.delete(); rq1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        // simultaneous request after reset: requester 0 first
        ws = 0;
        add(0, 4'h1, 1'b1, 32'h01010101, 4'h1, 3'd0, 1'b0);
        add(1, 4'h2, 1'b1, 32'h02020202, 4'h2, 3'd1, 1'b0);
        exp_push(2'b01, 1'b0, 32'h0, 1'b0, 4'h1, 1'b1, 32'h01010101, 4'h1, 3'd0, 1);
        exp_push(2'b10, 1'b1, 32'h0, 1'b0, 4'h2, 1'b1, 32'h02020202, 4'h2, 3'd1, 1);
        drain(100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule

// File: doc/axi_apb_arbiter.md
AXI_APB_ARBITER -- requirements
Module: axi_apb_arbiter

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 4, address width of all ports.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, data width of all ports; strobe width = AXI_DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 16, ACCESS-phase cycle limit; 0 disables the timeout.
REQ-004 S_AXI_ACLK  in  1  single clock, all logic rising-edge.
REQ-005 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-006 S_PSEL  in  2  requester select, bit i = requester i.
REQ-007 S_PENABLE  in  2  requester enable phase.
REQ-008 S_PADDR  in  2*AXI_ADDR_WIDTH  requester address, slice i.
REQ-009 S_PWRITE  in  2  requester direction, 1 = write.
REQ-010 S_PWDATA  in  2*AXI_DATA_WIDTH  requester write data.
REQ-011 S_PSTRB  in  2*AXI_DATA_WIDTH/8  requester byte strobes.
REQ-012 S_PPROT  in  6  requester protection, 3 bits per requester.
REQ-013 S_PREADY  out  2  completion to requester i.
REQ-014 S_PRDATA  out  AXI_DATA_WIDTH  read data, shared, valid while S_PREADY[i]=1.
REQ-015 S_PSLVERR  out  1  error, shared, valid while S_PREADY[i]=1.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  downstream APB control.
REQ-017 PADDR  out  AXI_ADDR_WIDTH;  PWDATA  out  AXI_DATA_WIDTH;  PSTRB  out  AXI_DATA_WIDTH/8;  PPROT  out  3  downstream APB payload.
REQ-018 PREADY  in  1;  PRDATA  in  AXI_DATA_WIDTH;  PSLVERR  in  1  downstream APB response.
REQ-019 GRANT  out  1  index of requester owning the current or last transfer.

Function
REQ-020 The block SHALL share one downstream APB slave between two APB requesters via FSM states IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-021 IDLE: a requester is pending when S_PSEL[i]=1 (either phase); with no pending requester the block SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: single pending requester wins; both pending -> requester != GRANT wins; GRANT updates on the IDLE->SETUP edge.
REQ-023 On IDLE->SETUP the block SHALL capture the winner's PADDR/PWRITE/PWDATA/PSTRB/PPROT and hold them constant on the downstream port until DONE.
REQ-024 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-025 ACCESS: PSEL=1, PENABLE=1; on sampled PREADY=1 -> DONE, registering PRDATA (reads; 0 for writes) and PSLVERR.
REQ-026 Timeout: cycle counter cleared on SETUP->ACCESS, increments each ACCESS cycle without PREADY; when it reaches TIMEOUT -> DONE with S_PSLVERR=1, S_PRDATA=0.
REQ-027 Counter width SHALL be $clog2(TIMEOUT+1) bits (min 1), saturating, never wrapping.
REQ-028 DONE: PSEL=PENABLE=0, S_PREADY[GRANT]=1 for exactly one cycle, other bit 0, then IDLE.
REQ-029 S_PREADY SHALL be 0 in every state except DONE; S_PRDATA/S_PSLVERR held until the next DONE.
REQ-030 Latency: S_PSEL sampled in IDLE at edge n, zero-wait slave -> S_PREADY high in cycle after edge n+2; each slave wait state adds one cycle.
REQ-031 Back-to-back: requester deasserting S_PSEL the cycle after S_PREADY SHALL not be re-granted; the other requester, if pending, SHALL be granted at the next IDLE edge.
REQ-032 A requester whose S_PSEL drops mid-transfer SHALL not abort the downstream transfer; DONE still occurs.
REQ-033 PREADY/PRDATA/PSLVERR outside ACCESS SHALL be ignored.

Reset
REQ-034 S_AXI_ARESET=1 SHALL immediately force IDLE, GRANT=1 (requester 0 wins first), counter 0, and every output 0, including mid-transfer.

Verification
REQ-035 Single write: S_PSEL=01, PADDR0=0x4, PWDATA0=0xDEADBEEF, PREADY=1 -> one SETUP, one ACCESS with PADDR=0x4, PWDATA=0xDEADBEEF, S_PREADY=01 for one cycle, S_PSLVERR=0.
REQ-036 Contention: S_PSEL=11 held continuously -> grants alternate 0,1,0,1; GRANT matches; no overlapping S_PREADY.
REQ-037 Read with 3 wait states: PRDATA=0x12345678 on PREADY -> ACCESS lasts 4 cycles, S_PRDATA=0x12345678 with S_PREADY=10 when requester 1 granted.
REQ-038 Timeout: TIMEOUT=16, PREADY held 0 -> DONE after 16 ACCESS cycles, S_PSLVERR=1, S_PRDATA=0, PSEL drops.
REQ-039 Slave error: PSLVERR=1 with PREADY -> S_PSLVERR=1 for the granted requester only.
REQ-040 Reset mid-ACCESS: assert S_AXI_ARESET asynchronously -> PSEL=PENABLE=0 and S_PREADY=00 before the next edge; after release requester 0 wins a simultaneous request.
